region_scanner: RTL and testbench



---
 rtl/region_scanner_if.sv | 21 ++
 rtl/region_scanner.sv | 125 ++++++++++++
 tb/tb_region_scanner.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/region_scanner_if.sv
// Tracker-side bus for region_scanner: pixel coordinates and the tracker result in,
// region select and press events out.
interface region_scanner_if;
  logic [9:0] x;
  logic [9:0] y;
  logic       regiao_detectada;
  logic [1:0] region;
  logic       press_valid;
  logic [1:0] press_region;
  logic [3:0] held_mask;

  modport master (
    output x, y, regiao_detectada,
    input  region, press_valid, press_region, held_mask
  );

  modport slave (
    input  x, y, regiao_detectada,
    output region, press_valid, press_region, held_mask
  );
endinterface

// File: rtl/region_scanner.sv
// Time-multiplexes the green tracker over the four pad regions, one region per frame,
// and debounces each region's per-frame result into held state and press pulses.
module region_scanner #(
  parameter int WIDTH         = 640,
  parameter int HEIGHT        = 480,
  parameter int CONFIRM_EVALS = 3,
  parameter int RELEASE_EVALS = 2
) (
  input logic             clk,
  input logic             rst_n,
  region_scanner_if.slave bus
);

  if (WIDTH < 1 || WIDTH > 1024 || HEIGHT < 1 || HEIGHT > 1024 ||
      CONFIRM_EVALS < 1 || CONFIRM_EVALS > 7 ||
      RELEASE_EVALS < 1 || RELEASE_EVALS > 7) begin : g_param_check
    $error("region_scanner: parameter out of range");
  end

  localparam logic [2:0] CONFIRM_N = 3'(CONFIRM_EVALS);
  localparam logic [2:0] RELEASE_N = 3'(RELEASE_EVALS);

  typedef enum logic {IDLE = 1'b0, PRESSED = 1'b1} pad_state_t;

  pad_state_t state_q [4];
  pad_state_t state_d [4];
  logic [2:0] cnt_q   [4];
  logic [2:0] cnt_d   [4];

  logic [1:0] region_q, region_d;
  logic [1:0] press_region_q, press_region_d;
  logic       press_valid_q, press_valid_d;
  logic       hit_q, hit_d;
  logic       armed_q, armed_d;
  logic       prev_origin_q;

  logic       at_origin;
  logic       frame_start;
  logic [2:0] cnt_inc;
  logic [3:0] held;

  assign at_origin   = (bus.x == 10'd0) && (bus.y == 10'd0);
  assign frame_start = at_origin && !prev_origin_q;
  assign cnt_inc     = cnt_q[region_q] + 3'd1;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    region_d       = region_q;
    press_region_d = press_region_q;
    press_valid_d  = 1'b0;
    hit_d          = hit_q;
    armed_d        = armed_q;

    if (frame_start) begin
      hit_d   = 1'b0;
      armed_d = 1'b1;
      // The very first frame_start after reset closes a partial frame: arm only.
      if (armed_q) begin
        region_d = region_q + 2'd1;
        if (state_q[region_q] == IDLE) begin
          if (!hit_q) begin
            cnt_d[region_q] = 3'd0;
          end else if (cnt_inc == CONFIRM_N) begin
            state_d[region_q] = PRESSED;
            cnt_d[region_q]   = 3'd0;
            press_valid_d     = 1'b1;
            press_region_d    = region_q;
          end else begin
            cnt_d[region_q] = cnt_inc;
          end
        end else begin
          if (hit_q) begin
            cnt_d[region_q] = 3'd0;
          end else if (cnt_inc == RELEASE_N) begin
            state_d[region_q] = IDLE;
            cnt_d[region_q]   = 3'd0;
          end else begin
            cnt_d[region_q] = cnt_inc;
          end
        end
      end
    end else if (!at_origin && bus.regiao_detectada) begin
      // Origin cycles are skipped: the tracker is clearing its counters there.
      hit_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 4; r++) begin
        state_q[r] <= IDLE;
        cnt_q[r]   <= 3'd0;
      end
      region_q       <= 2'd0;
      press_region_q <= 2'd0;
      press_valid_q  <= 1'b0;
      hit_q          <= 1'b0;
      armed_q        <= 1'b0;
      prev_origin_q  <= 1'b1;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      region_q       <= region_d;
      press_region_q <= press_region_d;
      press_valid_q  <= press_valid_d;
      hit_q          <= hit_d;
      armed_q        <= armed_d;
      prev_origin_q  <= at_origin;
    end
  end

  always_comb begin
    held = 4'b0000;
    for (int r = 0; r < 4; r++) begin
      held[r] = (state_q[r] == PRESSED);
    end
  end

  assign bus.region       = region_q;
  assign bus.press_valid  = press_valid_q;
  assign bus.press_region = press_region_q;
  assign bus.held_mask    = held;

endmodule

// File: tb/tb_region_scanner.sv
// Directed bench for region_scanner on a small 8x4 frame, with a frame-level
// reference model compared every cycle plus hand-computed checkpoints.
module tb_region_scanner;
  localparam int W    = 8;
  localparam int H    = 4;
  localparam int CONF = 3;
  localparam int REL  = 2;
  localparam int LAST = W * H - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  region_scanner_if bus ();

  region_scanner #(
    .WIDTH(W), .HEIGHT(H), .CONFIRM_EVALS(CONF), .RELEASE_EVALS(REL)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: per-region pressed flag and run length of the events
  // that move it toward the other state.
  int m_region, m_pr, m_r;
  bit m_pv, m_hit, m_armed, m_prev, m_org;
  bit m_pressed [4];
  int m_run     [4];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_region = 0; m_pr = 0; m_pv = 0; m_hit = 0; m_armed = 0; m_prev = 1;
      for (int r = 0; r < 4; r++) begin
        m_pressed[r] = 0;
        m_run[r]     = 0;
      end
    end else begin
      m_org = (bus.x == 0 && bus.y == 0);
      m_pv  = 0;
      if (m_org && !m_prev) begin
        if (m_armed) begin
          m_r = m_region;
          if (!m_pressed[m_r]) begin
            m_run[m_r] = m_hit ? m_run[m_r] + 1 : 0;
            if (m_run[m_r] == CONF) begin
              m_pressed[m_r] = 1; m_run[m_r] = 0; m_pv = 1; m_pr = m_r;
            end
          end else begin
            m_run[m_r] = m_hit ? 0 : m_run[m_r] + 1;
            if (m_run[m_r] == REL) begin
              m_pressed[m_r] = 0; m_run[m_r] = 0;
            end
          end
          m_region = (m_region + 1) % 4;
        end
        m_armed = 1;
        m_hit   = 0;
      end else if (!m_org && bus.regiao_detectada) begin
        m_hit = 1;
      end
      m_prev = m_org;
    end
  end

  always @(negedge clk) begin
    logic [3:0] exp_held;
    exp_held = {m_pressed[3], m_pressed[2], m_pressed[1], m_pressed[0]};
    tests++;
    if (bus.region !== 2'(m_region) || bus.held_mask !== exp_held ||
        bus.press_valid !== m_pv || bus.press_region !== 2'(m_pr)) begin
      fails++;
      $display("FAIL model_cmp t=%0t region got %0d want %0d, held got %b want %b, pv got %b want %b, pr got %0d want %0d",
               $time, bus.region, m_region, bus.held_mask, exp_held,
               bus.press_valid, m_pv, bus.press_region, m_pr);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic origin(input int n, input logic det);
    bus.x = 10'd0;
    bus.y = 10'd0;
    bus.regiao_detectada = det;
    repeat (n) step();
  endtask

  // Scan pixel indices from..to; the tracker answers per the currently selected region.
  task automatic scan(input int from, input int to, input logic [3:0] mask);
    for (int i = from; i <= to; i++) begin
      bus.x = 10'(i % W);
      bus.y = 10'(i / W);
      bus.regiao_detectada = mask[bus.region];
      step();
    end
  endtask

  task automatic reset_arm();
    rst_n = 1'b0;
    bus.x = 10'd0; bus.y = 10'd0; bus.regiao_detectada = 1'b0;
    step();
    rst_n = 1'b1;
    origin(2, 1'b0);
    scan(1, LAST, 4'b0000);
    origin(1, 1'b0);
  endtask

  initial begin
    bus.x = 10'd0; bus.y = 10'd0; bus.regiao_detectada = 1'b0;
    step();
    step();
    chk("rst_region", bus.region, 0);
    chk("rst_held", bus.held_mask, 0);
    chk("rst_pv", bus.press_valid, 0);
    chk("rst_pr", bus.press_region, 0);

    // Reset release at origin, partial frame, arming origin, first commit.
    rst_n = 1'b1;
    origin(5, 1'b1);
    chk("dwell_after_rst_region", bus.region, 0);
    scan(1, LAST, 4'b1111);
    origin(1, 1'b1);
    chk("arm_no_commit_region", bus.region, 0);
    chk("arm_no_commit_pv", bus.press_valid, 0);
    scan(1, LAST, 4'b1111);
    origin(1, 1'b1);
    chk("first_commit_region", bus.region, 1);
    chk("first_commit_held", bus.held_mask, 0);
    chk("first_commit_pv", bus.press_valid, 0);

    // Confirm, hold and release region 2.
    reset_arm();
    for (int f = 0; f < 36; f++) begin
      scan(1, LAST, (f <= 26) ? 4'b0100 : 4'b0000);
      origin(1, 1'b0);
      chk($sformatf("confirm_pv_f%0d", f), bus.press_valid, (f == 10) ? 1 : 0);
      if (f == 10) chk("confirm_pr", bus.press_region, 2);
      chk($sformatf("confirm_held_f%0d", f), bus.held_mask,
          (f >= 10 && f <= 33) ? 4 : 0);
    end

    // Broken confirm on region 1: hit, hit, miss, hit, hit, hit.
    reset_arm();
    for (int f = 0; f < 24; f++) begin
      scan(1, LAST, (f == 9) ? 4'b0000 : 4'b0010);
      origin(1, 1'b0);
      chk($sformatf("broken_pv_f%0d", f), bus.press_valid, (f == 21) ? 1 : 0);
      if (f == 21) chk("broken_pr", bus.press_region, 1);
      chk($sformatf("broken_held_f%0d", f), bus.held_mask, (f >= 21) ? 2 : 0);
    end

    // Origin dwell with detection asserted, plus region wrap.
    for (int f = 24; f < 30; f++) begin
      scan(1, LAST, 4'b0000);
      if (f == 28) origin(10, 1'b1);
      else         origin(1, 1'b0);
      if (f == 25) chk("dwell_miss1_held", bus.held_mask, 2);
      if (f == 27) chk("wrap_region", bus.region, 0);
      if (f == 28) begin
        chk("dwell_single_commit_region", bus.region, 1);
        chk("dwell_pv", bus.press_valid, 0);
      end
      if (f == 29) chk("dwell_no_credit_held", bus.held_mask, 0);
    end

    // Mid-frame reset with region 3 two hits in.
    reset_arm();
    for (int f = 0; f < 11; f++) begin
      scan(1, LAST, 4'b1000);
      origin(1, 1'b0);
    end
    chk("pre_midrst_region", bus.region, 3);
    chk("pre_midrst_held", bus.held_mask, 0);
    scan(1, 10, 4'b1000);
    rst_n = 1'b0;
    #1;
    chk("midrst_region", bus.region, 0);
    chk("midrst_held", bus.held_mask, 0);
    chk("midrst_pv", bus.press_valid, 0);
    chk("midrst_pr", bus.press_region, 0);
    step();
    rst_n = 1'b1;
    scan(11, LAST, 4'b1000);
    origin(1, 1'b0);
    chk("rearm_region", bus.region, 0);
    for (int f = 0; f < 16; f++) begin
      scan(1, LAST, 4'b1000);
      origin(1, 1'b0);
      chk($sformatf("rearm_pv_f%0d", f), bus.press_valid, (f == 11) ? 1 : 0);
      if (f == 11) chk("rearm_pr", bus.press_region, 3);
      chk($sformatf("rearm_held_f%0d", f), bus.held_mask, (f >= 11) ? 8 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
